pifo_sched: RTL and testbench
=============================

# pifo_sched

Parametrised single-push/single-pop PIFO scheduler: a rank-sorted shift-register array for the flow scheduling tree. It generalises the earlier fixed-width dual-push scheduler with parametrised rank, value and flow widths, and valid/ready handshakes. It adds three behaviours: FIFO ordering among equal ranks, per-flow occupancy caps, and an optional evict-on-full mode. It sits between the classifier (push side) and the egress arbiter (pop side).

## Interface
- SIZE, 16, entry count (≥2)
- RANK_W, 16, rank width; unsigned, lower value pops first
- VALUE_W, 32, payload width
- FLOWS, 8, number of flows (≥2)
- FLOW_CAP, SIZE, max resident entries per flow (1..SIZE)
- EVICT, 0, 1 = full-array push of better rank evicts tail entry
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- push_valid  in  1  push request
- push_ready  out  1  push accepted when valid&ready
- push_rank  in  RANK_W  rank
- push_value  in  VALUE_W  payload
- push_flow  in  $clog2(FLOWS)  flow id
- pop_valid  out  1  head entry present
- pop_ready  in  1  consumer takes head
- pop_rank / pop_value / pop_flow  out  RANK_W / VALUE_W / $clog2(FLOWS)  head entry fields
- evict_valid  out  1  one-cycle pulse: tail entry dropped
- evict_value / evict_flow  out  VALUE_W / $clog2(FLOWS)  dropped entry
- count  out  $clog2(SIZE+1)  occupancy

## Operation
- Array entry[0..SIZE-1]: rank, value, flow, valid. Valid entries are contiguous from 0 and sorted non-decreasing by rank; entry[0] is the head.
- Insert index = first i where !valid[i] or push_rank < rank[i] (strict). Equal ranks therefore queue behind existing entries (FIFO per rank).
- Push fire: entries at index ≥ idx shift up by one; the new entry is written at idx. flow_cnt[push_flow] increments.
- Pop fire: head is removed, remaining entries shift down by one, and flow_cnt[pop_flow] decrements.
- Simultaneous push+pop: pop removes the head presented this cycle; push uses the index computed on pre-pop contents, then the combined shift writes to idx-1 (or 0 if idx=0). count is unchanged.
- push_ready = flow_cnt[push_flow] < FLOW_CAP AND (count < SIZE OR (EVICT AND push_rank < rank[SIZE-1])). push_ready may depend on push_rank/push_flow but never on push_valid. It ignores same-cycle pop (conservative).
- Eviction (EVICT=1, full, accepted): entry[SIZE-1] is dropped, evict_* are registered with its fields, and flow_cnt of the evicted flow decrements; count stays SIZE. If the evicted flow equals push_flow, the net flow count is unchanged.
- Eviction never occurs when a pop fires in the same cycle; the entry is accepted normally.
- pop_valid = count != 0. pop_* outputs are undefined when pop_valid=0. pop_ready without pop_valid has no effect.
- push_flow ≥ FLOWS: push_ready=0.

## Timing
- Reset (async assert, sync deassert at clk): all valid=0, count=0, flow_cnt=0, pop_valid=0, evict_valid=0, push_ready reflects empty state (1 for legal flows).
- Push-to-visible latency: 1 cycle. An entry accepted at edge N can appear on pop_* after edge N.
- Pop: head leaves at the accepting edge; the next head appears in the same cycle after that edge.
- evict_valid: high exactly the cycle after the accepting edge.
- One push and one pop maximum per cycle.
- Reset mid-operation discards all contents; no eviction pulse is generated.

## Structure
- Package pifo_pkg: entry_t field-width localparam helpers, clog2-based width macros, and a rank_lt compare function. No struct parameterised by module parameters is placed in the package; the entry struct is local.
- Sub-module pifo_flow_counters: per-flow occupancy counters with inc/dec ports (handling inc and dec of the same flow in one cycle) and a cap_ok output per requested flow.

## Test plan
- Push ranks 5,3,9,3 (values A,B,C,D), then pop ×4 -> values B,D,A,C, with count 4→0 and pop_valid low after.
- Full array (SIZE=4, ranks 1,2,3,4), EVICT=0, push rank 0 -> push_ready=0. With EVICT=1, push rank 0 -> accepted, evict_valid pulses with rank-4 entry, head rank 0.
- FLOW_CAP=2: push flow 3 twice -> third flow-3 push sees push_ready=0, while a flow-1 push is accepted. Pop a flow-3 entry -> flow-3 push_ready returns 1.
- Simultaneous push rank 2 and pop with head rank 1, contents 1,4 -> after edge, head rank 2, then 4; count unchanged.
- Assert rst asynchronously mid-burst -> outputs clear without a clock edge, pop_valid=0, count=0, evict_valid=0.

Source files
------------

// File: rtl/pifo_pkg.sv
// rtl/pifo_pkg.sv - shared width helpers and rank compare for the PIFO scheduler
package pifo_pkg;

    // Widest rank the shared compare handles; narrower ranks are zero-extended.
    localparam int RANK_CMP_W = 64;

    // Flow id width, never narrower than one bit.
    function automatic int flow_w(input int flows);
        return (flows < 2) ? 1 : $clog2(flows);
    endfunction

    // Width of a counter that must hold 0..n inclusive.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Strict rank order: lower rank pops first, equal ranks keep arrival order.
    function automatic logic rank_lt(input logic [RANK_CMP_W-1:0] a,
                                     input logic [RANK_CMP_W-1:0] b);
        return a < b;
    endfunction

endpackage

// File: rtl/pifo_flow_counters.sv
// rtl/pifo_flow_counters.sv - per-flow resident entry counters with cap check
module pifo_flow_counters
    import pifo_pkg::*;
#(
    parameter int FLOWS    = 8,
    parameter int FLOW_CAP = 16,
    parameter int FW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic [FW-1:0] inc_flow,
    input  logic          dec,
    input  logic [FW-1:0] dec_flow,
    input  logic [FW-1:0] query_flow,
    output logic          cap_ok
);

    localparam int KW = count_w(FLOW_CAP);

    logic [KW-1:0] cnt_q [FLOWS];

    // An inc and dec hitting the same flow in one cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < FLOWS; f++) cnt_q[f] <= '0;
        end else begin
            for (int f = 0; f < FLOWS; f++) begin
                if ((inc && inc_flow == FW'(f)) && !(dec && dec_flow == FW'(f)))
                    cnt_q[f] <= cnt_q[f] + KW'(1);
                else if ((dec && dec_flow == FW'(f)) && !(inc && inc_flow == FW'(f)))
                    cnt_q[f] <= cnt_q[f] - KW'(1);
            end
        end
    end

    // Out-of-range flow ids match no counter and so are never under cap.
    always_comb begin
        cap_ok = 1'b0;
        for (int f = 0; f < FLOWS; f++)
            if (query_flow == FW'(f)) cap_ok = (cnt_q[f] < KW'(FLOW_CAP));
    end

endmodule

// File: rtl/pifo_sched.sv
// rtl/pifo_sched.sv - rank-sorted single-push/single-pop PIFO scheduler
module pifo_sched
    import pifo_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int RANK_W   = 16,
    parameter int VALUE_W  = 32,
    parameter int FLOWS    = 8,
    parameter int FLOW_CAP = SIZE,
    parameter int EVICT    = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [RANK_W-1:0]          push_rank,
    input  logic [VALUE_W-1:0]         push_value,
    input  logic [flow_w(FLOWS)-1:0]   push_flow,
    output logic                       pop_valid,
    input  logic                       pop_ready,
    output logic [RANK_W-1:0]          pop_rank,
    output logic [VALUE_W-1:0]         pop_value,
    output logic [flow_w(FLOWS)-1:0]   pop_flow,
    output logic                       evict_valid,
    output logic [VALUE_W-1:0]         evict_value,
    output logic [flow_w(FLOWS)-1:0]   evict_flow,
    output logic [count_w(SIZE)-1:0]   count
);

    localparam int FW = flow_w(FLOWS);
    localparam int CW = count_w(SIZE);

    typedef struct packed {
        logic [RANK_W-1:0]  rank;
        logic [VALUE_W-1:0] value;
        logic [FW-1:0]      flow;
    } entry_t;

    entry_t        ent_q  [SIZE];
    entry_t        ent_d  [SIZE];
    entry_t        ent_up [SIZE];
    entry_t        ent_dn [SIZE];
    entry_t        new_ent;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] ins_idx;
    logic [CW-1:0] ins_pos;
    logic          full;
    logic          tail_better;
    logic          cap_ok;
    logic          push_fire;
    logic          pop_fire;
    logic          evict_fire;
    logic [FW-1:0] dec_flow;

    // Valid entries occupy 0..count-1, so slot validity is just i < count.
    always_comb begin
        ins_idx = CW'(SIZE);
        for (int i = SIZE - 1; i >= 0; i--)
            if (!(CW'(i) < count_q) ||
                rank_lt(RANK_CMP_W'(push_rank), RANK_CMP_W'(ent_q[i].rank)))
                ins_idx = CW'(i);
    end

    // Handshake decode; push_ready deliberately ignores a same-cycle pop.
    always_comb begin
        full        = (count_q == CW'(SIZE));
        tail_better = rank_lt(RANK_CMP_W'(push_rank), RANK_CMP_W'(ent_q[SIZE-1].rank));
        push_ready  = cap_ok && (!full || ((EVICT != 0) && tail_better));
        push_fire   = push_valid && push_ready;
        pop_fire    = pop_ready && (count_q != '0);
        evict_fire  = push_fire && !pop_fire && full;
        dec_flow    = pop_fire ? ent_q[0].flow : ent_q[SIZE-1].flow;
        ins_pos     = (pop_fire && ins_idx != '0) ? ins_idx - CW'(1) : ins_idx;
    end

    // Neighbour views of the array used by the up/down shifts.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            ent_up[i] = '0;
            ent_dn[i] = '0;
        end
        for (int i = 1; i < SIZE; i++) begin
            ent_up[i]   = ent_q[i-1];
            ent_dn[i-1] = ent_q[i];
        end
    end

    // Next array contents for push, pop, or combined push+pop.
    always_comb begin
        new_ent.rank  = push_rank;
        new_ent.value = push_value;
        new_ent.flow  = push_flow;
        for (int i = 0; i < SIZE; i++) begin
            ent_d[i] = ent_q[i];
            if (push_fire && pop_fire) begin
                if (CW'(i) < ins_pos)       ent_d[i] = ent_dn[i];
                else if (CW'(i) == ins_pos) ent_d[i] = new_ent;
            end else if (push_fire) begin
                if (CW'(i) == ins_pos)      ent_d[i] = new_ent;
                else if (CW'(i) > ins_pos)  ent_d[i] = ent_up[i];
            end else if (pop_fire) begin
                ent_d[i] = ent_dn[i];
            end
        end
        count_d = count_q;
        if (push_fire && !pop_fire && !evict_fire) count_d = count_q + CW'(1);
        else if (pop_fire && !push_fire)           count_d = count_q - CW'(1);
    end

    // Array and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            for (int i = 0; i < SIZE; i++) ent_q[i] <= '0;
        end else begin
            count_q <= count_d;
            for (int i = 0; i < SIZE; i++) ent_q[i] <= ent_d[i];
        end
    end

    // One-cycle report of the tail entry pushed out by a better-ranked push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evict_valid <= 1'b0;
            evict_value <= '0;
            evict_flow  <= '0;
        end else begin
            evict_valid <= evict_fire;
            if (evict_fire) begin
                evict_value <= ent_q[SIZE-1].value;
                evict_flow  <= ent_q[SIZE-1].flow;
            end
        end
    end

    pifo_flow_counters #(
        .FLOWS    (FLOWS),
        .FLOW_CAP (FLOW_CAP),
        .FW       (FW)
    ) u_flow_counters (
        .clk        (clk),
        .rst        (rst),
        .inc        (push_fire),
        .inc_flow   (push_flow),
        .dec        (pop_fire || evict_fire),
        .dec_flow   (dec_flow),
        .query_flow (push_flow),
        .cap_ok     (cap_ok)
    );

    assign pop_valid = (count_q != '0);
    assign pop_rank  = ent_q[0].rank;
    assign pop_value = ent_q[0].value;
    assign pop_flow  = ent_q[0].flow;
    assign count     = count_q;

endmodule

// File: tb/tb_pifo_sched.sv
// tb/tb_pifo_sched.sv - directed table-driven bench for pifo_sched
module tb_pifo_sched;

    logic        clk;
    logic        rst;

    logic        a_push_valid, a_push_ready, a_pop_valid, a_pop_ready, a_evict_valid;
    logic [7:0]  a_push_rank, a_pop_rank;
    logic [15:0] a_push_value, a_pop_value, a_evict_value;
    logic [2:0]  a_push_flow, a_pop_flow, a_evict_flow, a_count;

    logic        b_push_valid, b_push_ready, b_pop_valid, b_pop_ready, b_evict_valid;
    logic [7:0]  b_push_rank, b_pop_rank;
    logic [15:0] b_push_value, b_pop_value, b_evict_value;
    logic [2:0]  b_push_flow, b_pop_flow, b_evict_flow, b_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        pv;
        logic [7:0]  rank;
        logic [15:0] val;
        logic [2:0]  flow;
        logic        pr;
        logic        e_rdy;
        logic        e_pv;
        logic [7:0]  e_rank;
        logic [15:0] e_val;
        logic [2:0]  e_flow;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vq[$];

    pifo_sched #(.SIZE(4), .RANK_W(8), .VALUE_W(16), .FLOWS(6), .FLOW_CAP(2), .EVICT(0)) dut_a (
        .clk(clk), .rst(rst),
        .push_valid(a_push_valid), .push_ready(a_push_ready), .push_rank(a_push_rank),
        .push_value(a_push_value), .push_flow(a_push_flow),
        .pop_valid(a_pop_valid), .pop_ready(a_pop_ready), .pop_rank(a_pop_rank),
        .pop_value(a_pop_value), .pop_flow(a_pop_flow),
        .evict_valid(a_evict_valid), .evict_value(a_evict_value), .evict_flow(a_evict_flow),
        .count(a_count)
    );

    pifo_sched #(.SIZE(4), .RANK_W(8), .VALUE_W(16), .FLOWS(6), .FLOW_CAP(2), .EVICT(1)) dut_b (
        .clk(clk), .rst(rst),
        .push_valid(b_push_valid), .push_ready(b_push_ready), .push_rank(b_push_rank),
        .push_value(b_push_value), .push_flow(b_push_flow),
        .pop_valid(b_pop_valid), .pop_ready(b_pop_ready), .pop_rank(b_pop_rank),
        .pop_value(b_pop_value), .pop_flow(b_pop_flow),
        .evict_valid(b_evict_valid), .evict_value(b_evict_value), .evict_flow(b_evict_flow),
        .count(b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input int pv, input int rank, input int val, input int flow, input int pr,
                       input int e_rdy, input int e_pv, input int e_rank, input int e_val,
                       input int e_flow, input int e_cnt);
        vec_t v;
        v.pv = 1'(pv);         v.rank = 8'(rank);     v.val = 16'(val);
        v.flow = 3'(flow);     v.pr = 1'(pr);         v.e_rdy = 1'(e_rdy);
        v.e_pv = 1'(e_pv);     v.e_rank = 8'(e_rank); v.e_val = 16'(e_val);
        v.e_flow = 3'(e_flow); v.e_cnt = 3'(e_cnt);
        vq.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        a_push_valid = 0; a_push_rank = 0; a_push_value = 0; a_push_flow = 0; a_pop_ready = 0;
        b_push_valid = 0; b_push_rank = 0; b_push_value = 0; b_push_flow = 0; b_pop_ready = 0;

        // pv rank val flow pr | rdy pv rank val flow cnt  (expectations are pre-edge state)
        add(1, 5, 'hA, 0, 0,   1, 0, 0, 0, 0, 0);
        add(1, 3, 'hB, 1, 0,   1, 1, 5, 'hA, 0, 1);
        add(1, 9, 'hC, 2, 0,   1, 1, 3, 'hB, 1, 2);
        add(1, 3, 'hD, 3, 0,   1, 1, 3, 'hB, 1, 3);
        add(0, 0, 0,   4, 1,   0, 1, 3, 'hB, 1, 4);
        add(0, 0, 0,   4, 1,   1, 1, 3, 'hD, 3, 3);
        add(0, 0, 0,   4, 1,   1, 1, 5, 'hA, 0, 2);
        add(0, 0, 0,   4, 1,   1, 1, 9, 'hC, 2, 1);
        add(0, 0, 0,   4, 1,   1, 0, 0, 0, 0, 0);
        add(1, 7, 'h31, 3, 0,  1, 0, 0, 0, 0, 0);
        add(1, 8, 'h32, 3, 0,  1, 1, 7, 'h31, 3, 1);
        add(1, 1, 'h33, 3, 0,  0, 1, 7, 'h31, 3, 2);
        add(1, 6, 'h11, 1, 0,  1, 1, 7, 'h31, 3, 2);
        add(0, 1, 0,   3, 1,   0, 1, 6, 'h11, 1, 3);
        add(0, 1, 0,   3, 1,   0, 1, 7, 'h31, 3, 2);
        add(1, 1, 'h34, 3, 0,  1, 1, 8, 'h32, 3, 1);
        add(1, 0, 'h99, 7, 0,  0, 1, 1, 'h34, 3, 2);
        add(0, 0, 0,   0, 1,   1, 1, 1, 'h34, 3, 2);
        add(0, 0, 0,   0, 1,   1, 1, 8, 'h32, 3, 1);
        add(1, 1, 'h41, 0, 0,  1, 0, 0, 0, 0, 0);
        add(1, 4, 'h44, 1, 0,  1, 1, 1, 'h41, 0, 1);
        add(1, 2, 'h42, 2, 1,  1, 1, 1, 'h41, 0, 2);
        add(0, 0, 0,   0, 1,   1, 1, 2, 'h42, 2, 2);
        add(0, 0, 0,   0, 1,   1, 1, 4, 'h44, 1, 1);
        add(0, 0, 0,   0, 0,   1, 0, 0, 0, 0, 0);

        #3;
        chk("reset a pop_valid", 32'(a_pop_valid), 0);
        chk("reset a count", 32'(a_count), 0);
        chk("reset a evict_valid", 32'(a_evict_valid), 0);
        chk("reset a push_ready", 32'(a_push_ready), 1);
        chk("reset b pop_valid", 32'(b_pop_valid), 0);
        chk("reset b push_ready", 32'(b_push_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        foreach (vq[k]) begin
            @(negedge clk);
            a_push_valid = vq[k].pv;   a_push_rank = vq[k].rank; a_push_value = vq[k].val;
            a_push_flow  = vq[k].flow; a_pop_ready = vq[k].pr;
            #1;
            chk($sformatf("v%0d push_ready", k), 32'(a_push_ready), 32'(vq[k].e_rdy));
            chk($sformatf("v%0d pop_valid", k), 32'(a_pop_valid), 32'(vq[k].e_pv));
            chk($sformatf("v%0d count", k), 32'(a_count), 32'(vq[k].e_cnt));
            chk($sformatf("v%0d evict_valid", k), 32'(a_evict_valid), 0);
            if (vq[k].e_pv) begin
                chk($sformatf("v%0d pop_rank", k), 32'(a_pop_rank), 32'(vq[k].e_rank));
                chk($sformatf("v%0d pop_value", k), 32'(a_pop_value), 32'(vq[k].e_val));
                chk($sformatf("v%0d pop_flow", k), 32'(a_pop_flow), 32'(vq[k].e_flow));
            end
        end
        @(negedge clk);
        a_push_valid = 0; a_pop_ready = 0;

        // Evict-mode instance: fill with ranks 1..4.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            b_push_valid = 1; b_push_rank = 8'(k + 1); b_push_value = 16'(16'h51 + k);
            b_push_flow = 3'(k);
            #1 chk("b fill push_ready", 32'(b_push_ready), 1);
        end
        @(negedge clk);
        b_push_valid = 0; b_push_rank = 8'd5; b_push_flow = 3'd1;
        #1;
        chk("b full count", 32'(b_count), 4);
        chk("b full worse rank ready", 32'(b_push_ready), 0);
        b_push_rank = 8'd4;
        #1 chk("b full equal tail rank ready", 32'(b_push_ready), 0);
        b_push_rank = 8'd0; b_push_value = 16'h50; b_push_valid = 1;
        #1 chk("b full better rank ready", 32'(b_push_ready), 1);
        @(posedge clk);
        #1;
        b_push_valid = 0;
        chk("b evict_valid pulse", 32'(b_evict_valid), 1);
        chk("b evict_value", 32'(b_evict_value), 32'h54);
        chk("b evict_flow", 32'(b_evict_flow), 3);
        chk("b head rank after evict", 32'(b_pop_rank), 0);
        chk("b head value after evict", 32'(b_pop_value), 32'h50);
        chk("b count after evict", 32'(b_count), 4);
        @(posedge clk);
        #1;
        chk("b evict_valid drops", 32'(b_evict_valid), 0);
        b_push_valid = 1; b_push_rank = 8'd0; b_push_value = 16'h5F; b_push_flow = 3'd3;
        b_pop_ready = 1;
        #1 chk("b full push+pop ready", 32'(b_push_ready), 1);
        @(posedge clk);
        #1;
        b_push_valid = 0; b_pop_ready = 0;
        chk("b push+pop no evict", 32'(b_evict_valid), 0);
        chk("b push+pop head value", 32'(b_pop_value), 32'h5F);
        chk("b push+pop count", 32'(b_count), 4);
        b_push_valid = 1; b_push_rank = 8'd0; b_push_value = 16'h60; b_push_flow = 3'd0;
        #1 chk("b second evict ready", 32'(b_push_ready), 1);
        @(posedge clk);
        #1;
        b_push_valid = 0;
        chk("b second evict_valid", 32'(b_evict_valid), 1);
        chk("b second evict_value", 32'(b_evict_value), 32'h53);

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        chk("async rst evict_valid", 32'(b_evict_valid), 0);
        chk("async rst pop_valid", 32'(b_pop_valid), 0);
        chk("async rst count", 32'(b_count), 0);
        chk("async rst push_ready", 32'(b_push_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post rst count", 32'(b_count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
